// File: rtl/instr_fetch_if.sv
// instr_fetch_if: signal bundle around the fetch stage.
//   PC side     : pc_in, flush, pc_count
//   Memory side : imem_req, imem_addr, imem_ack, imem_rdata
//   Decode side : inst, inst_pc, inst_valid, inst_ready, fetch_fault
// modport master is the fetch stage's view; modport slave is the view of the
// surrounding PC / memory / decode logic.
interface instr_fetch_if;
   logic [31:0] pc_in;
   logic        flush;
   logic        pc_count;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic        fetch_fault;

   modport master (
      input  pc_in, flush, imem_ack, imem_rdata, inst_ready,
      output pc_count, imem_req, imem_addr, inst, inst_pc, inst_valid, fetch_fault
   );

   modport slave (
      output pc_in, flush, imem_ack, imem_rdata, inst_ready,
      input  pc_count, imem_req, imem_addr, inst, inst_pc, inst_valid, fetch_fault
   );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage between the PC and decode.
// Latches pc_in, performs a req/ack read of instruction memory, presents the
// returned word to decode with a valid/ready handshake and strobes pc_count
// when decode accepts. A flush redirects the stage; a response already in
// flight is drained and discarded.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - instr_fetch_if.master (PC, instruction memory and decode signals)
// Build option: FETCH_ALIGN_CHECK_EN - a misaligned pc_in skips the memory
//   read and presents NOP_WORD with fetch_fault set. When undefined,
//   fetch_fault is 0 and imem_addr[1:0] is forced to 2'b00.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0040_0000,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input logic         clk,
   input logic         rst,
   instr_fetch_if.master bus
);

   typedef enum logic [1:0] {ISSUE, WAIT, VALID, DRAIN} state_t;

   state_t      state;
   state_t      state_next;
   logic [31:0] req_addr;
   logic [31:0] inst_q;
   logic [31:0] inst_pc_q;
   logic        misaligned;
   logic        req_o;
   logic        valid_o;
   logic        count_o;
   logic        fault_o;

`ifdef FETCH_ALIGN_CHECK_EN
   logic fault_q;
   assign misaligned = (bus.pc_in[1:0] != 2'b00);
`else
   assign misaligned = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ISSUE;
      else      state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         ISSUE: if (!bus.flush) state_next = misaligned ? VALID : WAIT;
         WAIT: begin
            if (bus.imem_ack)   state_next = bus.flush ? ISSUE : VALID;
            else if (bus.flush) state_next = DRAIN;
         end
         // Redirect already taken; only the outstanding ack matters here.
         DRAIN: if (bus.imem_ack) state_next = ISSUE;
         VALID: if (bus.flush || bus.inst_ready) state_next = ISSUE;
         default: state_next = ISSUE;
      endcase
   end

   // Output logic
   always_comb begin
      req_o   = (state == WAIT) || (state == DRAIN);
      valid_o = (state == VALID);
      // flush wins over a same-cycle accept: the PC takes the redirect instead.
      count_o = (state == VALID) && bus.inst_ready && !bus.flush;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_o = fault_q;
`else
      fault_o = 1'b0;
`endif
   end

   // Request address and instruction holding registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         req_addr  <= RESET_PC;
         inst_q    <= '0;
         inst_pc_q <= RESET_PC;
      end else begin
         if (state == ISSUE) begin
            req_addr <= bus.pc_in;
            if (misaligned && !bus.flush) begin
               inst_q    <= NOP_WORD;
               inst_pc_q <= bus.pc_in;
            end
         end
         if (state == WAIT && bus.imem_ack && !bus.flush) begin
            inst_q    <= bus.imem_rdata;
            inst_pc_q <= req_addr;
         end
      end
   end

`ifdef FETCH_ALIGN_CHECK_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         fault_q <= 1'b0;
      else if (state == ISSUE && misaligned && !bus.flush)
         fault_q <= 1'b1;
      else if (state == VALID && state_next != VALID)
         fault_q <= 1'b0;
   end
`endif

   assign bus.imem_req    = req_o;
`ifdef FETCH_ALIGN_CHECK_EN
   assign bus.imem_addr   = req_addr;
`else
   assign bus.imem_addr   = {req_addr[31:2], 2'b00};
`endif
   assign bus.inst        = inst_q;
   assign bus.inst_pc     = inst_pc_q;
   assign bus.inst_valid  = valid_o;
   assign bus.pc_count    = count_o;
   assign bus.fetch_fault = fault_o;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

   localparam logic [31:0] RP  = 32'h0040_0000;
   localparam logic [31:0] NOP = 32'h0000_0000;

   logic clk;
   logic rst;

   instr_fetch_if bus();

   instr_fetch #(.RESET_PC(RP), .NOP_WORD(NOP)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [31:0] pc_in;
      logic        flush;
      logic        ack;
      logic [31:0] rdata;
      logic        ready;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_inst;
      logic [31:0] e_pc;
      logic        e_cnt;
   } vec_t;

   vec_t tbl [32];

   int unsigned n_cmp;
   int unsigned n_bad;

   function automatic vec_t mk(logic r, logic [31:0] p, logic f, logic a, logic [31:0] d,
                               logic rd, logic q, logic [31:0] ad, logic v,
                               logic [31:0] ins, logic [31:0] ipc, logic c);
      vec_t t;
      t.rst = r; t.pc_in = p; t.flush = f; t.ack = a; t.rdata = d; t.ready = rd;
      t.e_req = q; t.e_addr = ad; t.e_valid = v; t.e_inst = ins; t.e_pc = ipc; t.e_cnt = c;
      return t;
   endfunction

   // Memory contents: a fixed scramble of the word address.
   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic f, input logic a, input logic [31:0] d, input logic rd);
      bus.flush = f; bus.imem_ack = a; bus.imem_rdata = d; bus.inst_ready = rd;
   endtask

   task automatic run_vec(input int unsigned i, input vec_t v);
      rst = v.rst;
      bus.pc_in = v.pc_in;
      drive(v.flush, v.ack, v.rdata, v.ready);
      @(negedge clk);
      chk($sformatf("v%0d imem_req", i),    {31'd0, bus.imem_req},   {31'd0, v.e_req});
      chk($sformatf("v%0d imem_addr", i),   bus.imem_addr,           v.e_addr);
      chk($sformatf("v%0d inst_valid", i),  {31'd0, bus.inst_valid}, {31'd0, v.e_valid});
      chk($sformatf("v%0d inst", i),        bus.inst,                v.e_inst);
      chk($sformatf("v%0d inst_pc", i),     bus.inst_pc,             v.e_pc);
      chk($sformatf("v%0d pc_count", i),    {31'd0, bus.pc_count},   {31'd0, v.e_cnt});
      chk($sformatf("v%0d fetch_fault", i), {31'd0, bus.fetch_fault}, 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic cyc;
      @(posedge clk); #1;
   endtask

   // Random-phase state
   logic [31:0] pc, pc_n, target, r;
   logic        exp_acc, stuck;
   logic        prev_req, prev_ack, prev_hold;
   logic [31:0] prev_addr, prev_inst, prev_ipc;
   int unsigned idle, ack_wait, ready_wait, n_acc;

   initial begin
      n_cmp = 0; n_bad = 0;
      rst = 1'b0;
      bus.pc_in = RP;
      drive(1'b0, 1'b0, '0, 1'b0);

      //          rst pc_in         fl ack rdata          rdy | req addr        val inst           inst_pc      cnt
      tbl[0]  = mk(0, RP,           0, 0, 32'h0,          0,   0, RP,          0, 32'h0,          RP,          0);
      tbl[1]  = mk(1, RP,           0, 0, 32'h0,          1,   0, RP,          0, 32'h0,          RP,          0);
      tbl[2]  = mk(1, RP,           0, 1, 32'h1111_1111,  1,   1, RP,          0, 32'h0,          RP,          0);
      tbl[3]  = mk(1, RP,           0, 0, 32'h0,          1,   0, RP,          1, 32'h1111_1111,  RP,          1);
      tbl[4]  = mk(1, RP+4,         0, 0, 32'h0,          1,   0, RP,          0, 32'h1111_1111,  RP,          0);
      for (int unsigned k = 5; k <= 8; k++)
         tbl[k] = mk(1, 32'hFFFF_0000, 0, 0, 32'h0,      0,   1, RP+4,        0, 32'h1111_1111,  RP,          0);
      tbl[9]  = mk(1, 32'hFFFF_0000,0, 1, 32'h2222_2222,  0,   1, RP+4,        0, 32'h1111_1111,  RP,          0);
      for (int unsigned k = 10; k <= 14; k++)
         tbl[k] = mk(1, 32'hFFFF_0000, 0, 0, 32'h0,      0,   0, RP+4,        1, 32'h2222_2222,  RP+4,        0);
      tbl[15] = mk(1, 32'hFFFF_0000,0, 0, 32'h0,          1,   0, RP+4,        1, 32'h2222_2222,  RP+4,        1);
      tbl[16] = mk(1, RP+8,         0, 0, 32'h0,          0,   0, RP+4,        0, 32'h2222_2222,  RP+4,        0);
      tbl[17] = mk(1, RP+8,         1, 0, 32'h0,          0,   1, RP+8,        0, 32'h2222_2222,  RP+4,        0);
      tbl[18] = mk(1, 32'h0040_0100,0, 0, 32'h0,          0,   1, RP+8,        0, 32'h2222_2222,  RP+4,        0);
      tbl[19] = mk(1, 32'h0040_0100,0, 1, 32'hDEAD_BEEF,  0,   1, RP+8,        0, 32'h2222_2222,  RP+4,        0);
      tbl[20] = mk(1, 32'h0040_0100,0, 0, 32'h0,          0,   0, RP+8,        0, 32'h2222_2222,  RP+4,        0);
      tbl[21] = mk(1, 32'hFFFF_0000,0, 1, 32'h3333_3333,  0,   1, 32'h0040_0100, 0, 32'h2222_2222, RP+4,        0);
      tbl[22] = mk(1, 32'h0040_0200,1, 0, 32'h0,          1,   0, 32'h0040_0100, 1, 32'h3333_3333, 32'h0040_0100, 0);
      tbl[23] = mk(1, 32'h0040_0200,0, 1, 32'hBAD0_BAD0,  1,   0, 32'h0040_0100, 0, 32'h3333_3333, 32'h0040_0100, 0);
      tbl[24] = mk(1, 32'hFFFF_0000,0, 1, 32'h4444_4444,  1,   1, 32'h0040_0200, 0, 32'h3333_3333, 32'h0040_0100, 0);
      tbl[25] = mk(1, 32'h0040_0204,0, 0, 32'h0,          1,   0, 32'h0040_0200, 1, 32'h4444_4444, 32'h0040_0200, 1);
      tbl[26] = mk(1, 32'h0040_0300,1, 1, 32'hBAD1_BAD1,  0,   0, 32'h0040_0200, 0, 32'h4444_4444, 32'h0040_0200, 0);
      tbl[27] = mk(1, 32'h0040_0400,0, 0, 32'h0,          0,   0, 32'h0040_0300, 0, 32'h4444_4444, 32'h0040_0200, 0);
      tbl[28] = mk(1, 32'h0,        1, 1, 32'h5555_5555,  0,   1, 32'h0040_0400, 0, 32'h4444_4444, 32'h0040_0200, 0);
      tbl[29] = mk(1, 32'h0040_0500,0, 1, 32'hBAD2_BAD2,  0,   0, 32'h0040_0400, 0, 32'h4444_4444, 32'h0040_0200, 0);
      tbl[30] = mk(1, 32'h0,        0, 1, 32'h6666_6666,  1,   1, 32'h0040_0500, 0, 32'h4444_4444, 32'h0040_0200, 0);
      tbl[31] = mk(1, 32'h0,        0, 0, 32'h0,          1,   0, 32'h0040_0500, 1, 32'h6666_6666, 32'h0040_0500, 1);

      #1;
      for (int unsigned i = 0; i < 32; i++) run_vec(i, tbl[i]);

      // Reset in the middle of a read drops imem_req without a clock edge.
      bus.pc_in = 32'h0040_0600;
      drive(1'b0, 1'b0, '0, 1'b0);
      cyc();
      chk("midrst req before", {31'd0, bus.imem_req}, 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("midrst req",     {31'd0, bus.imem_req},   32'd0);
      chk("midrst addr",    bus.imem_addr,           RP);
      chk("midrst valid",   {31'd0, bus.inst_valid}, 32'd0);
      chk("midrst inst",    bus.inst,                32'd0);
      chk("midrst inst_pc", bus.inst_pc,             RP);
      @(posedge clk); #1;
      rst = 1'b1;

`ifdef FETCH_ALIGN_CHECK_EN
      // Flush in the misaligned ISSUE cycle suppresses the fault.
      bus.pc_in = 32'h0040_0002;
      drive(1'b1, 1'b0, '0, 1'b0);
      @(negedge clk);
      chk("align flush fault", {31'd0, bus.fetch_fault}, 32'd0);
      cyc();
      drive(1'b0, 1'b0, '0, 1'b0);
      @(negedge clk);
      chk("align issue valid", {31'd0, bus.inst_valid}, 32'd0);
      cyc();
      @(negedge clk);
      chk("align req",     {31'd0, bus.imem_req},    32'd0);
      chk("align valid",   {31'd0, bus.inst_valid},  32'd1);
      chk("align inst",    bus.inst,                 NOP);
      chk("align inst_pc", bus.inst_pc,              32'h0040_0002);
      chk("align fault",   {31'd0, bus.fetch_fault}, 32'd1);
      chk("align count0",  {31'd0, bus.pc_count},    32'd0);
      cyc();
      bus.inst_ready = 1'b1;
      @(negedge clk);
      chk("align req2",    {31'd0, bus.imem_req},    32'd0);
      chk("align count1",  {31'd0, bus.pc_count},    32'd1);
      chk("align fault2",  {31'd0, bus.fetch_fault}, 32'd1);
      cyc();
      bus.pc_in = 32'h0040_0004;
      bus.inst_ready = 1'b0;
      @(negedge clk);
      chk("align fault clr", {31'd0, bus.fetch_fault}, 32'd0);
      chk("align valid clr", {31'd0, bus.inst_valid},  32'd0);
      cyc();
`else
      // Misaligned PC without the check: low address bits masked on the bus.
      bus.pc_in = 32'h0040_0803;
      drive(1'b0, 1'b0, '0, 1'b0);
      @(negedge clk);
      chk("mis issue req", {31'd0, bus.imem_req}, 32'd0);
      cyc();
      drive(1'b0, 1'b1, 32'h7777_7777, 1'b0);
      @(negedge clk);
      chk("mis req",   {31'd0, bus.imem_req},    32'd1);
      chk("mis addr",  bus.imem_addr,            32'h0040_0800);
      chk("mis fault", {31'd0, bus.fetch_fault}, 32'd0);
      cyc();
      drive(1'b0, 1'b0, '0, 1'b1);
      @(negedge clk);
      chk("mis valid",   {31'd0, bus.inst_valid}, 32'd1);
      chk("mis inst",    bus.inst,                32'h7777_7777);
      chk("mis inst_pc", bus.inst_pc,             32'h0040_0803);
      chk("mis count",   {31'd0, bus.pc_count},   32'd1);
      cyc();
`endif

      // Randomized run: the bench plays PC, memory and decode.
      rst = 1'b0;
      cyc();
      rst = 1'b1;
      pc = RP;
      bus.pc_in = pc;
      prev_req = 1'b0; prev_ack = 1'b0; prev_hold = 1'b0;
      prev_addr = '0; prev_inst = '0; prev_ipc = '0;
      idle = 0; ack_wait = 0; ready_wait = 0; n_acc = 0; stuck = 1'b0;
      for (int c = 0; c < 2000 && !stuck; c++) begin
         r = $urandom;
         target = {r[31:2], 2'b00};
         bus.flush = ($urandom % 10) == 0;
         bus.inst_ready = (($urandom % 2) == 0) || (ready_wait >= 6);
         if (bus.imem_req) begin
            bus.imem_ack = (($urandom % 3) == 0) || (ack_wait >= 5);
            bus.imem_rdata = bus.imem_ack ? mem(bus.imem_addr) : $urandom;
         end else begin
            bus.imem_ack = ($urandom % 4) == 0;
            bus.imem_rdata = $urandom;
         end
         @(negedge clk);
         exp_acc = bus.inst_valid && bus.inst_ready && !bus.flush;
         chk("rnd pc_count", {31'd0, bus.pc_count}, {31'd0, exp_acc});
         chk("rnd fault",    {31'd0, bus.fetch_fault}, 32'd0);
         if (exp_acc) begin
            n_acc++;
            chk("rnd inst_pc", bus.inst_pc, pc);
            chk("rnd inst",    bus.inst,    mem(pc));
         end
         if (prev_hold) begin
            chk("rnd hold valid",   {31'd0, bus.inst_valid}, 32'd1);
            chk("rnd hold inst",    bus.inst,    prev_inst);
            chk("rnd hold inst_pc", bus.inst_pc, prev_ipc);
         end
         if (prev_req && !prev_ack) begin
            chk("rnd req stable",  {31'd0, bus.imem_req}, 32'd1);
            chk("rnd addr stable", bus.imem_addr, prev_addr);
         end
         if (bus.imem_req && !prev_req)
            chk("rnd req addr", bus.imem_addr, pc);
         if (exp_acc || bus.flush) idle = 0;
         else idle++;
         if (idle > 40) begin
            n_cmp++; n_bad++;
            $display("FAIL rnd progress: actual=%0d idle cycles required<=40", idle);
            stuck = 1'b1;
         end
         ack_wait   = (bus.imem_req && !bus.imem_ack) ? ack_wait + 1 : 0;
         ready_wait = (bus.inst_valid && !bus.inst_ready) ? ready_wait + 1 : 0;
         prev_req  = bus.imem_req;
         prev_ack  = bus.imem_ack;
         prev_addr = bus.imem_addr;
         prev_hold = bus.inst_valid && !bus.inst_ready && !bus.flush;
         prev_inst = bus.inst;
         prev_ipc  = bus.inst_pc;
         if (bus.flush)   pc_n = target;
         else if (exp_acc) pc_n = pc + 32'd4;
         else             pc_n = pc;
         cyc();
         pc = pc_n;
         bus.pc_in = pc;
      end
      chk("rnd accept count", {31'd0, n_acc >= 50}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly downstream of the program counter.
- Latches the current PC, runs a req/ack read on the instruction memory, and holds the returned word in an output register with a valid/ready handshake to decode.
- Drives the PC's count input so the PC advances only when decode accepts an instruction.
- Handles redirect flushes, including discarding a memory response that is already in flight.

Parameters:
RESET_PC, 32'h00400000, value of imem_addr and inst_pc at reset
NOP_WORD, 32'h00000000, instruction word presented on a fault

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
pc_in  input  32  current PC from the PC stage
flush  input  1  redirect this cycle; same signal as the PC's shouldUseNewPC
pc_count  output  1  count strobe to the PC stage
imem_req  output  1  instruction memory read request
imem_addr  output  32  instruction memory word address
imem_ack  input  1  read complete; imem_rdata valid this cycle
imem_rdata  input  32  instruction memory read data
inst  output  32  fetched instruction
inst_pc  output  32  address of inst
inst_valid  output  1  inst/inst_pc valid
inst_ready  input  1  decode accepts this cycle
fetch_fault  output  1  inst is a fault NOP (see Optional Feature)

Behaviour:
- Interface: one clock, clk. rst is asynchronous and active-low.
- Reset (rst=0, async):
  - State = ISSUE; req_addr = RESET_PC.
  - inst = 0, inst_pc = RESET_PC; inst_valid, imem_req, pc_count, fetch_fault = 0.
  - Reset mid-transaction drops imem_req immediately; no drain is performed.
- States: ISSUE, WAIT, VALID, DRAIN.
- ISSUE (1 cycle):
  - req_addr <= pc_in; imem_req = 0.
  - Next state is WAIT; stays ISSUE if flush=1, so the new PC is re-latched.
- WAIT:
  - imem_req = 1; imem_addr = req_addr. Both stay stable until ack.
  - ack=1, flush=0: inst <= imem_rdata, inst_pc <= req_addr, go to VALID.
  - ack=1, flush=1: discard data, go to ISSUE.
  - ack=0, flush=1: go to DRAIN.
  - ack=0, flush=0: stay in WAIT.
- DRAIN:
  - imem_req = 1; imem_addr = req_addr.
  - On ack, discard data and go to ISSUE. flush here is ignored (already redirected).
- VALID:
  - inst_valid = 1. inst/inst_pc are held stable while inst_ready=0.
  - accept = inst_valid & inst_ready.
  - accept & !flush: pc_count = 1 for exactly that cycle; go to ISSUE.
  - flush (with or without ready): instruction dropped, pc_count = 0, go to ISSUE. Decode must ignore a same-cycle accept.
- pc_count is combinational and is 0 in every state other than VALID.
- pc_in is only assumed stable in the ISSUE cycle.
- Throughput with zero-wait memory and ready held high: one instruction per 3 cycles (ISSUE, WAIT, VALID).
- imem_addr carries full 32 bits; no increment arithmetic is done here (the PC owns +4).
- imem_ack outside WAIT/DRAIN is ignored.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - In ISSUE, if pc_in[1:0] != 0, no memory request is issued.
  - Next state is VALID with inst = NOP_WORD, inst_pc = pc_in, fetch_fault = 1.
  - fetch_fault clears when leaving VALID.
  - Flush in that ISSUE cycle takes priority: no fault is raised.
- Undefined:
  - fetch_fault tied to 0.
  - imem_addr[1:0] forced to 2'b00.

Test Plan:
- Reset release, pc_in=0x00400000, ack on first WAIT cycle, ready=1 -> imem_req high in cycle 2 with addr 0x00400000; inst_valid in cycle 3; pc_count=1 in cycle 3 only.
- Ack delayed 4 cycles -> imem_req and imem_addr stable for all 4 cycles; one valid instruction; pc_count pulses once.
- Hold inst_ready=0 for 5 cycles in VALID -> inst and inst_pc unchanged, pc_count=0; single pc_count pulse on the ready cycle.
- flush in WAIT with ack=0, then ack 2 cycles later with data 0xDEADBEEF -> DRAIN entered, data discarded, inst_valid never set for it; next ISSUE latches new pc_in 0x00400100.
- flush and inst_ready together in VALID -> pc_count=0, inst_valid=0 next cycle, refetch from the redirect address.
- FETCH_ALIGN_CHECK_EN defined, pc_in=0x00400002 -> imem_req never asserted; inst=0, fetch_fault=1, inst_pc=0x00400002.
